// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// key_code layout is {row_idx, col_idx}.
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int KEY_W = ROW_W + COL_W;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    // Index of the lowest-numbered row pulled low; 0 when none is low.
    function automatic logic [ROW_W-1:0] lowest_low(input logic [ROWS-1:0] rows);
        lowest_low = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                lowest_low = ROW_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the decoded key outputs.
// master = scanner side, slave = keypad / consumer side.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [ROWS-1:0]  row;
    logic [COLS-1:0]  col;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             keypad_pressed;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output keypad_pressed
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  keypad_pressed
    );
endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous row inputs.
// Flops idle high so an unpressed (pulled-up) row reads as released out of reset.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '1;
            sync_reg <= '1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad decoder with tick-paced debounce of press and release.
// Once a key is seen, the column freezes and only the latched row is watched.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    keypad_scanner_if.master   kp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_N + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_N);

    logic [ROWS-1:0]  row_sync;
    logic [DIV_W-1:0] div_reg;
    logic             tick;

    state_t           state_reg, state_next;
    logic [COL_W-1:0] col_sel_reg, col_sel_next;
    logic [ROW_W-1:0] row_idx_reg, row_idx_next;
    logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
    logic [KEY_W-1:0] key_code_reg, key_code_next;
    logic             key_valid_reg, key_valid_next;
    logic             pressed_reg, pressed_next;

    logic             any_low;
    logic             row_hit;
    logic [DEB_W-1:0] deb_inc;
    logic             deb_done;

    keypad_sync #(.WIDTH(ROWS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kp.row),
        .q     (row_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign tick     = (div_reg == DIV_LAST);
    assign any_low  = ~&row_sync;
    assign row_hit  = ~row_sync[row_idx_reg];
    // Saturating increment: the counter parks at DEBOUNCE_N instead of wrapping.
    assign deb_inc  = (deb_cnt_reg == DEB_MAX) ? deb_cnt_reg : deb_cnt_reg + 1'b1;
    assign deb_done = (deb_inc == DEB_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_SCAN;
            col_sel_reg   <= '0;
            row_idx_reg   <= '0;
            deb_cnt_reg   <= '0;
            key_code_reg  <= '0;
            key_valid_reg <= 1'b0;
            pressed_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_sel_reg   <= col_sel_next;
            row_idx_reg   <= row_idx_next;
            deb_cnt_reg   <= deb_cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            pressed_reg   <= pressed_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        col_sel_next   = col_sel_reg;
        row_idx_next   = row_idx_reg;
        deb_cnt_next   = deb_cnt_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        pressed_next   = pressed_reg;

        if (tick) begin
            unique case (state_reg)
                ST_SCAN: begin
                    if (any_low) begin
                        row_idx_next = lowest_low(row_sync);
                        deb_cnt_next = '0;
                        state_next   = ST_DEBOUNCE;
                    end else begin
                        col_sel_next = col_sel_reg + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_hit) begin
                        deb_cnt_next = deb_inc;
                        if (deb_done) begin
                            state_next     = ST_HELD;
                            key_code_next  = {row_idx_reg, col_sel_reg};
                            key_valid_next = 1'b1;
                            pressed_next   = 1'b1;
                        end
                    end else begin
                        state_next   = ST_SCAN;
                        col_sel_next = col_sel_reg + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!row_hit) begin
                        deb_cnt_next = '0;
                        state_next   = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (row_hit) begin
                        // Bounce during release: back to held without re-announcing the key.
                        deb_cnt_next = '0;
                        state_next   = ST_HELD;
                    end else begin
                        deb_cnt_next = deb_inc;
                        if (deb_done) begin
                            pressed_next = 1'b0;
                            state_next   = ST_SCAN;
                            col_sel_next = col_sel_reg + 1'b1;
                        end
                    end
                end
                default: state_next = ST_SCAN;
            endcase
        end
    end

    wire [COLS-1:0] col_drive;

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign col_drive[gi] = (col_sel_reg != COL_W'(gi));
    end

    assign kp.col            = col_drive;
    assign kp.key_code       = key_code_reg;
    assign kp.key_valid      = key_valid_reg;
    assign kp.keypad_pressed = pressed_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a modelled 4x4 switch matrix, table-driven key presses,
// and hand-built bounce / multi-row / reset sequences with a key_code scoreboard.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE_N = 3;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys  = '0;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];
    logic        prev_valid = 1'b0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE_N (DEBOUNCE_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // Switch matrix: a closed key pulls its row low while its column is driven low.
    always_comb begin
        kp.row = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kp.col[c]) begin
                    kp.row[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock, then score any key_valid pulse against the queue of announced keys.
    task automatic step();
        logic [3:0] exp_code;
        @(negedge clk);
        if (kp.key_valid === 1'b1) begin
            chk("valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got key_valid=1 code=%0h expected no pulse at %0t",
                         kp.key_code, $time);
            end else begin
                exp_code = exp_q.pop_front();
                chk("valid_code", {28'd0, kp.key_code}, {28'd0, exp_code});
                $display("key_valid code=%b at %0t", kp.key_code, $time);
            end
        end
        prev_valid = kp.key_valid;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pressed(input logic lvl, input int budget, input string name, output int n);
        n = 0;
        while (kp.keypad_pressed !== lvl && n < budget) begin
            step();
            n++;
        end
        chk(name, {31'd0, kp.keypad_pressed}, {31'd0, lvl});
    endtask

    task automatic wait_col(input logic [3:0] c, input int budget);
        int n = 0;
        while (kp.col !== c && n < budget) begin
            step();
            n++;
        end
        chk("wait_col", {28'd0, kp.col}, {28'd0, c});
    endtask

    initial begin
        vec_t       vecs[5];
        logic [3:0] ec;
        int         n;

        vecs[0] = '{r: 1, c: 2, code: 4'b0110};
        vecs[1] = '{r: 0, c: 0, code: 4'b0000};
        vecs[2] = '{r: 3, c: 3, code: 4'b1111};
        vecs[3] = '{r: 2, c: 1, code: 4'b1001};
        vecs[4] = '{r: 0, c: 3, code: 4'b0011};

        // Reset and idle scan
        steps(3);
        chk("rst_col", {28'd0, kp.col}, 32'hE);
        chk("rst_code", {28'd0, kp.key_code}, 32'd0);
        chk("rst_valid", {31'd0, kp.key_valid}, 32'd0);
        chk("rst_pressed", {31'd0, kp.keypad_pressed}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            steps(i == 0 ? 2 : SCAN_DIV);
            ec = ~(4'b0001 << (i % 4));
            chk("idle_col", {28'd0, kp.col}, {28'd0, ec});
            $display("idle step %0d col=%b", i, kp.col);
        end

        // Table-driven single key press / hold / release
        foreach (vecs[v]) begin
            exp_q.push_back(vecs[v].code);
            keys = '0;
            keys[vecs[v].r*4 + vecs[v].c] = 1'b1;
            wait_pressed(1'b1, 120, "press", n);
            chk("press_code", {28'd0, kp.key_code}, {28'd0, vecs[v].code});
            ec = ~(4'b0001 << vecs[v].c);
            chk("held_col", {28'd0, kp.col}, {28'd0, ec});
            steps(20 * SCAN_DIV);
            chk("hold_pressed", {31'd0, kp.keypad_pressed}, 32'd1);
            chk("hold_col", {28'd0, kp.col}, {28'd0, ec});
            chk("sb_drained", exp_q.size(), 32'd0);
            keys = '0;
            wait_pressed(1'b0, 60, "release", n);
            chk("release_delay", {31'd0, (n >= DEBOUNCE_N * SCAN_DIV)}, 32'd1);
            ec = ~(4'b0001 << ((vecs[v].c + 1) % 4));
            chk("next_col", {28'd0, kp.col}, {28'd0, ec});
            chk("code_kept", {28'd0, kp.key_code}, {28'd0, vecs[v].code});
            $display("key r=%0d c=%0d code=%b released after %0d cycles",
                     vecs[v].r, vecs[v].c, kp.key_code, n);
        end

        // Bouncing contact: alternating every tick must never confirm
        wait_col(4'b1011, 40);
        for (int k = 0; k < 8; k++) begin
            keys[6] = ~keys[6];
            steps(SCAN_DIV);
        end
        chk("bounce_no_press", {31'd0, kp.keypad_pressed}, 32'd0);
        exp_q.push_back(4'b0110);
        keys[6] = 1'b1;
        wait_pressed(1'b1, 120, "bounce_press", n);
        chk("bounce_code", {28'd0, kp.key_code}, 32'h6);
        keys = '0;
        wait_pressed(1'b0, 60, "bounce_release", n);
        $display("bounce sequence done code=%b", kp.key_code);

        // Two rows on column 0: lowest row wins, other row ignored while held
        exp_q.push_back(4'b0000);
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        wait_pressed(1'b1, 120, "multi_press", n);
        chk("multi_code", {28'd0, kp.key_code}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            keys[8] = ~keys[8];
            steps(SCAN_DIV);
        end
        chk("multi_hold", {31'd0, kp.keypad_pressed}, 32'd1);
        chk("multi_col", {28'd0, kp.col}, 32'hE);
        chk("multi_code_kept", {28'd0, kp.key_code}, 32'h0);
        keys = '0;
        wait_pressed(1'b0, 60, "multi_release", n);
        $display("multi-row sequence done code=%b", kp.key_code);

        // Reset while held aborts everything
        exp_q.push_back(4'b1101);
        keys[13] = 1'b1;
        wait_pressed(1'b1, 120, "rst_held_press", n);
        steps(2 * SCAN_DIV);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pressed", {31'd0, kp.keypad_pressed}, 32'd0);
        chk("mid_rst_code", {28'd0, kp.key_code}, 32'd0);
        chk("mid_rst_valid", {31'd0, kp.key_valid}, 32'd0);
        chk("mid_rst_col", {28'd0, kp.col}, 32'hE);
        steps(3);
        keys = '0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_col", {28'd0, kp.col}, 32'hE);
        steps(8 * SCAN_DIV);
        chk("post_rst_pressed", {31'd0, kp.keypad_pressed}, 32'd0);
        chk("final_sb_empty", exp_q.size(), 32'd0);
        $display("reset-while-held sequence done col=%b", kp.col);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
